// File: rtl/dmem_responder_pkg.sv
// Shared types and sizing helpers for the data-memory responder.
// Holds the FSM state encoding and the width functions used by the top and its counter.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_e;

    // Counter width for a given latency; never narrower than one bit.
    function automatic int cnt_width(input int latency);
        return (latency < 2) ? 1 : $clog2(latency);
    endfunction

    function automatic int idx_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

    localparam int DEF_LATENCY = 4;
    localparam int LAT_W       = cnt_width(DEF_LATENCY);

endpackage

// File: rtl/dmem_responder_lat_counter.sv
// Loadable down-counter that times the BUSY phase of a memory access.
// Stops at zero and reports it through a zero flag.
module dmem_lat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: serialises one load/store at a time,
// stalls the pipeline for a fixed latency and pulses ack on completion.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        ack_o,
    output logic [31:0] data_o,
    output logic        busy_o
);

    localparam int IDX_W = idx_width(DEPTH_WORDS);
    localparam int CNT_W = cnt_width(LATENCY);

    state_e           state_q, state_d;
    logic             accept, complete, cnt_zero;
    logic             we_p0;
    logic [IDX_W-1:0] idx_p0;
    logic [31:0]      data_p0;
    logic [31:0]      mem [DEPTH_WORDS];

    // Byte offset and bits above the index field do not select a word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

    dmem_lat_counter #(
        .W (CNT_W)
    ) u_lat_counter (
        .clk      (clk_i),
        .rst      (rst_i),
        .clr      (state_q == ACK),
        .load     (accept),
        .load_val (CNT_W'(LATENCY - 1)),
        .en       (state_q == BUSY),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        complete = 1'b0;
        busy_o   = 1'b0;
        case (state_q)
            IDLE: begin
                busy_o = req_i;
                if (req_i) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy_o = 1'b1;
                if (cnt_zero) begin
                    complete = 1'b1;
                    state_d  = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ack_o   <= 1'b0;
            data_o  <= '0;
        end else begin
            state_q <= state_d;
            ack_o   <= complete;
            if (complete && !we_p0) begin
                data_o <= mem[idx_p0];
            end
        end
    end

    // Request capture: held for the whole access so mid-flight input changes are ignored.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_p0   <= we_i;
            idx_p0  <= addr_i[IDX_W+1:2];
            data_p0 <= data_i;
        end
    end

    // Reset on the completing edge suppresses the write.
    always_ff @(posedge clk_i) begin
        if (complete && we_p0 && !rst_i) begin
            mem[idx_p0] <= data_p0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// load/store traffic checked against a word-array reference model.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req, we, ack, busy;
    logic [31:0] addr, wdata, rdata;
    logic        req1, we1, ack1, busy1;
    logic [31:0] addr1, wdata1, rdata1;

    dmem_responder #(.DEPTH_WORDS(32), .LATENCY(4)) dut (
        .clk_i (clk), .rst_i (rst), .req_i (req), .we_i (we),
        .addr_i (addr), .data_i (wdata),
        .ack_o (ack), .data_o (rdata), .busy_o (busy)
    );

    dmem_responder #(.DEPTH_WORDS(32), .LATENCY(1)) dut1 (
        .clk_i (clk), .rst_i (rst), .req_i (req1), .we_i (we1),
        .addr_i (addr1), .data_i (wdata1),
        .ack_o (ack1), .data_o (rdata1), .busy_o (busy1)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mem_model [32];
    logic [31:0] exp_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the LATENCY=4 instance, starting in an IDLE cycle.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input bit garble);
        int          idx;
        logic [31:0] prev;
        idx  = int'((a >> 2) % 32);
        prev = exp_rd;
        if (w) mem_model[idx] = d;
        else   exp_rd = mem_model[idx];
        req = 1'b1; we = w; addr = a; wdata = d;
        #1;
        chk("busy_on_req", 32'(busy), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            chk("busy_in_busy", 32'(busy), 32'd1);
            chk("no_early_ack", 32'(ack), 32'd0);
            chk("data_hold_busy", rdata, prev);
            if (garble) begin
                we = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
            end
        end
        cyc();
        chk("ack_pulse", 32'(ack), 32'd1);
        chk("busy_in_ack", 32'(busy), 32'd0);
        chk("data_at_ack", rdata, exp_rd);
        req = 1'b0; we = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
        cyc();
        chk("ack_cleared", 32'(ack), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("data_hold_idle", rdata, exp_rd);
    endtask

    initial begin
        int ack_exp [6];
        int busy_exp [6];
        ack_exp  = '{0, 0, 1, 0, 0, 1};
        busy_exp = '{1, 1, 0, 1, 1, 0};

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        exp_rd = '0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_data", rdata, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ack_l1", 32'(ack1), 32'd0);
        chk("reset_data_l1", rdata1, 32'd0);

        // LATENCY=1 with req held through ACK: store then load of the same word.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0C; wdata1 = 32'h5A5A0F0F;
        #1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) cyc();
            chk("l1_ack_seq", 32'(ack1), 32'(ack_exp[c]));
            chk("l1_busy_seq", 32'(busy1), 32'(busy_exp[c]));
            if (c == 2) begin
                chk("l1_store_data", rdata1, 32'd0);
                we1 = 1'b0; wdata1 = '0;
            end
            if (c == 5) chk("l1_load_data", rdata1, 32'h5A5A0F0F);
        end
        req1 = 1'b0;
        cyc();
        chk("l1_idle_ack", 32'(ack1), 32'd0);
        chk("l1_idle_busy", 32'(busy1), 32'd0);

        // Store/load round trip, aliasing and mid-flight input changes.
        access(1'b1, 32'h08, 32'hDEADBEEF, 1'b0);
        access(1'b0, 32'h08, 32'h0, 1'b0);
        access(1'b1, 32'h04, 32'h11111111, 1'b0);
        access(1'b0, 32'h84, 32'h0, 1'b0);
        access(1'b0, 32'h07, 32'h0, 1'b0);
        access(1'b1, 32'h10, 32'hA5A5A5A5, 1'b1);
        access(1'b0, 32'h10, 32'h0, 1'b1);

        // Reset in the middle of BUSY aborts a store.
        access(1'b1, 32'h20, 32'hCAFEF00D, 1'b0);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678;
        #1;
        cyc(); cyc();
        rst = 1'b1; req = 1'b0;
        cyc();
        exp_rd = '0;
        chk("rst_busy_ack", 32'(ack), 32'd0);
        chk("rst_busy_busy", 32'(busy), 32'd0);
        chk("rst_busy_data", rdata, 32'd0);
        rst = 1'b0;
        cyc();
        chk("rst_busy_noack", 32'(ack), 32'd0);
        access(1'b0, 32'h20, 32'h0, 1'b0);

        // Reset on the completing edge of a store suppresses the write.
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h77777777;
        #1;
        for (int c = 1; c <= 4; c++) cyc();
        rst = 1'b1; req = 1'b0;
        cyc();
        exp_rd = '0;
        chk("rst_commit_ack", 32'(ack), 32'd0);
        chk("rst_commit_data", rdata, 32'd0);
        rst = 1'b0;
        cyc();
        chk("rst_commit_noack", 32'(ack), 32'd0);
        access(1'b0, 32'h20, 32'h0, 1'b0);

        // Randomized traffic: fill every word, then mixed loads/stores with wrapped addresses.
        for (int i = 0; i < 32; i++) begin
            access(1'b1, ($urandom & 32'hFFFFFF83) | (32'(i) << 2), $urandom, 1'b1);
        end
        for (int i = 0; i < 40; i++) begin
            access(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
